// File: rtl/calc_arbiter_pkg.sv
// calc_pkg: shared types and constants for the calc_arbiter slice.
//   DATA_W      operand/result width (5-bit, wrap-around arithmetic)
//   MODE_ADD    req_mode value selecting a + b
//   MODE_SUB    req_mode value selecting a - b
//   arb_state_t arbiter FSM encoding, also exported on the debug state port
package calc_pkg;

   localparam int DATA_W = 5;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/calc_arbiter_if.sv
// calc_arbiter_if: request and response channels of calc_arbiter.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The requester side keeps valid
// and its payload stable until it sees ready; the responder side keeps
// rsp_valid_o, rsp_result_o and rsp_id_o stable until rsp_ready_i is high.
// A requester may drop valid before being granted, with no side effect.
//
// Signals (named from the arbiter's point of view):
//   req_valid_i  [NUM_REQ]          per-requester operation valid
//   req_a_i      [NUM_REQ*DATA_W]   operand A, requester k at [5k+4:5k]
//   req_b_i      [NUM_REQ*DATA_W]   operand B, same packing
//   req_mode_i   [NUM_REQ]          0 = add, 1 = subtract
//   req_ready_o  [NUM_REQ]          one-hot grant
//   rsp_valid_o                     result available
//   rsp_result_o [DATA_W]           result mod 32
//   rsp_id_o     [ID_W]             requester that issued the op
//   rsp_ready_i                     consumer accepts response
//   busy_o                          arbiter FSM not idle
//   ops_done_o   [8]                saturating count of completed responses
interface calc_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                  req_valid_i;
   logic [NUM_REQ*calc_pkg::DATA_W-1:0] req_a_i;
   logic [NUM_REQ*calc_pkg::DATA_W-1:0] req_b_i;
   logic [NUM_REQ-1:0]                  req_mode_i;
   logic [NUM_REQ-1:0]                  req_ready_o;
   logic                                rsp_valid_o;
   logic [calc_pkg::DATA_W-1:0]         rsp_result_o;
   logic [ID_W-1:0]                     rsp_id_o;
   logic                                rsp_ready_i;
   logic                                busy_o;
   logic [7:0]                          ops_done_o;

   // Arbiter side.
   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_mode_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, busy_o, ops_done_o
   );

   // Client / consumer side.
   modport master (
      output req_valid_i, req_a_i, req_b_i, req_mode_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, busy_o, ops_done_o
   );

endinterface

// File: rtl/addsub.sv
// addsub: shared combinational 5-bit adder/subtractor, wrap-around, no flags.
//   a_i, b_i  operands
//   mode_i    MODE_ADD -> a + b, MODE_SUB -> a - b
//   result_o  result mod 2**DATA_W
module addsub
   import calc_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              mode_i,
   output logic [DATA_W-1:0] result_o
);

   assign result_o = (mode_i == MODE_SUB) ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/calc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i    request vector
//   ptr_i    index with highest priority this round
//   grant_o  one-hot grant of the first set request at or above ptr_i (wrapping)
//   idx_o    binary index of grant_o
//   any_o    at least one request set
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Modulo keeps the scan correct for non-power-of-two NUM_REQ.
         j = (int'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one addsub datapath among NUM_REQ
// requesters. IDLE grants and registers the operands, EXEC captures the
// addsub result, RESP holds the tagged result until the consumer takes it.
//   clk_i    clock
//   rst_i    synchronous active-high reset (wins over clear_i)
//   clear_i  synchronous abort of the operation in flight
//   bus      calc_arbiter_if.slave request/response channels and status
//   state_o  current FSM state, for observation
module calc_arbiter
   import calc_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clear_i,
   calc_arbiter_if.slave  bus,
   output arb_state_t     state_o
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, id_q, rsp_id_q, grant_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                grant_any;
   logic [DATA_W-1:0]   a_q, b_q, result_q, alu_result;
   logic                mode_q;
   logic [7:0]          ops_done_q;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i   (bus.req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   addsub u_addsub (
      .a_i      (a_q),
      .b_i      (b_q),
      .mode_i   (mode_q),
      .result_o (alu_result)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state; clear_i overrides any handshake.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs. Grant is masked during reset and clear so no handshake can
   // be seen by a requester on a cycle the arbiter will not act on.
   always_comb begin
      bus.req_ready_o  = (state_q == IDLE && !clear_i && !rst_i) ? grant : '0;
      bus.rsp_valid_o  = (state_q == RESP);
      bus.busy_o       = (state_q != IDLE);
      bus.rsp_result_o = result_q;
      bus.rsp_id_o     = rsp_id_q;
      bus.ops_done_o   = ops_done_q;
      state_o          = state_q;
   end

   // Datapath and bookkeeping registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q        <= '0;
         b_q        <= '0;
         mode_q     <= MODE_ADD;
         id_q       <= '0;
         ptr_q      <= '0;
         result_q   <= '0;
         rsp_id_q   <= '0;
         ops_done_q <= '0;
      end else if (clear_i) begin
         // Result/ID registers are left alone: rsp_valid_o drops, so they are
         // not observable as a response. ops_done_q survives clear.
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= MODE_ADD;
         id_q   <= '0;
         ptr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  a_q    <= bus.req_a_i[int'(grant_idx)*DATA_W +: DATA_W];
                  b_q    <= bus.req_b_i[int'(grant_idx)*DATA_W +: DATA_W];
                  mode_q <= bus.req_mode_i[grant_idx];
                  id_q   <= grant_idx;
               end
            end
            EXEC: begin
               result_q <= alu_result;
               rsp_id_q <= id_q;
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  // Requester just served gets lowest priority next round.
                  ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                  if (ops_done_q != 8'hFF) ops_done_q <= ops_done_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed self-checking bench for calc_arbiter (NUM_REQ=4).
module tb_calc_arbiter;
   import calc_pkg::*;

   localparam int N = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic clear;
   arb_state_t dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   calc_arbiter_if #(.NUM_REQ(N)) bus ();

   calc_arbiter #(.NUM_REQ(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus),
      .state_o (dbg_state)
   );

   int vectors;
   int miscompares;
   int exp_done;
   logic [6:0] exp_q[$];   // {id, result}

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [4:0] a, input logic [4:0] b, input logic m);
      bus.req_valid_i[k]       = 1'b1;
      bus.req_a_i[k*5 +: 5]    = a;
      bus.req_b_i[k*5 +: 5]    = b;
      bus.req_mode_i[k]        = m;
   endtask

   task automatic idle_reqs();
      bus.req_valid_i = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      clear = 1'b0;
      bus.req_valid_i = 4'hF;
      bus.req_a_i = '0;
      bus.req_b_i = '0;
      bus.req_mode_i = '0;
      bus.rsp_ready_i = 1'b0;
      tick();
      tick();
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o);
      end
      tick();
      rst = 1'b0;
      idle_reqs();
      @(negedge clk);
      vectors++;
      if (dbg_state !== IDLE || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: state=%0d valid=%b busy=%b expected 0/0/0",
                  dbg_state, bus.rsp_valid_o, bus.busy_o);
      end
      vectors++;
      if (bus.rsp_result_o !== 5'd0 || bus.rsp_id_o !== 2'd0 || bus.ops_done_o !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_data: result=%0d id=%0d done=%0d expected 0/0/0",
                  bus.rsp_result_o, bus.rsp_id_o, bus.ops_done_o);
      end
      exp_done = 0;
      tick();
   endtask

   task automatic test_single();
      set_req(2, 5'd7, 5'd5, MODE_ADD);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0100) begin
         miscompares++;
         $display("FAIL single_grant: got %b expected 0100", bus.req_ready_o);
      end
      tick();
      idle_reqs();
      @(negedge clk);
      vectors++;
      if (dbg_state !== EXEC || bus.busy_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_exec: state=%0d busy=%b valid=%b expected EXEC/1/0",
                  dbg_state, bus.busy_o, bus.rsp_valid_o);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 5'd12 || bus.rsp_id_o !== 2'd2) begin
         miscompares++;
         $display("FAIL single_rsp: valid=%b result=%0d id=%0d expected 1/12/2",
                  bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_id_o);
      end
      tick();
      exp_done++;
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ops_done_o !== 8'(exp_done)) begin
         miscompares++;
         $display("FAIL single_done: valid=%b busy=%b done=%0d expected 0/0/%0d",
                  bus.rsp_valid_o, bus.busy_o, bus.ops_done_o, exp_done);
      end
      tick();
   endtask

   task automatic test_wrap_sub();
      int         ks[2]   = '{0, 1};
      logic [4:0] as[2]   = '{5'd3, 5'd20};
      logic [4:0] bs[2]   = '{5'd5, 5'd15};
      logic       ms[2]   = '{MODE_SUB, MODE_ADD};
      logic [4:0] rs[2]   = '{5'd30, 5'd3};
      logic [3:0] oh;
      for (int t = 0; t < 2; t++) begin
         set_req(ks[t], as[t], bs[t], ms[t]);
         bus.rsp_ready_i = 1'b1;
         oh = 4'b0001 << ks[t];
         @(negedge clk);
         vectors++;
         if (bus.req_ready_o !== oh) begin
            miscompares++;
            $display("FAIL wrap_grant%0d: got %b expected %b", t, bus.req_ready_o, oh);
         end
         tick();
         idle_reqs();
         tick();
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== rs[t] || bus.rsp_id_o !== 2'(ks[t])) begin
            miscompares++;
            $display("FAIL wrap_rsp%0d: valid=%b result=%0d id=%0d expected 1/%0d/%0d",
                     t, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_id_o, rs[t], ks[t]);
         end
         tick();
         exp_done++;
      end
      @(negedge clk);
      vectors++;
      if (bus.ops_done_o !== 8'(exp_done)) begin
         miscompares++;
         $display("FAIL wrap_done: got %0d expected %0d", bus.ops_done_o, exp_done);
      end
      tick();
   endtask

   task automatic test_backpressure();
      set_req(2, 5'd9, 5'd12, MODE_SUB);   // 9 - 12 wraps to 29
      bus.rsp_ready_i = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_grant: got %b expected 0100", bus.req_ready_o);
      end
      tick();
      idle_reqs();
      set_req(0, 5'd1, 5'd1, MODE_ADD);    // competing requester held during stall
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 5'd29 || bus.rsp_id_o !== 2'd2
             || bus.req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_hold%0d: valid=%b result=%0d id=%0d ready=%b expected 1/29/2/0000",
                     c, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_id_o, bus.req_ready_o);
         end
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      idle_reqs();
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid_o !== 1'b1 || bus.ops_done_o !== 8'(exp_done)) begin
         miscompares++;
         $display("FAIL bp_release: valid=%b done=%0d expected 1/%0d",
                  bus.rsp_valid_o, bus.ops_done_o, exp_done);
      end
      tick();
      exp_done++;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid_o !== 1'b0 || bus.ops_done_o !== 8'(exp_done)) begin
            miscompares++;
            $display("FAIL bp_once%0d: valid=%b done=%0d expected 0/%0d",
                     c, bus.rsp_valid_o, bus.ops_done_o, exp_done);
         end
         tick();
      end
   endtask

   task automatic test_clear();
      // Abort during EXEC.
      set_req(0, 5'd4, 5'd4, MODE_ADD);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0001) begin
         miscompares++;
         $display("FAIL clr_grant: got %b expected 0001", bus.req_ready_o);
      end
      tick();
      idle_reqs();
      clear = 1'b1;
      @(negedge clk);
      vectors++;
      if (dbg_state !== EXEC) begin
         miscompares++;
         $display("FAIL clr_in_exec: state=%0d expected %0d", dbg_state, EXEC);
      end
      tick();
      clear = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (dbg_state !== IDLE || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0
             || bus.ops_done_o !== 8'(exp_done)) begin
            miscompares++;
            $display("FAIL clr_exec_after%0d: state=%0d valid=%b busy=%b done=%0d expected IDLE/0/0/%0d",
                     c, dbg_state, bus.rsp_valid_o, bus.busy_o, bus.ops_done_o, exp_done);
         end
         tick();
      end
      // clear masks a pending grant in the same cycle.
      set_req(2, 5'd1, 5'd2, MODE_ADD);
      clear = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL clr_mask: got %b expected 0000", bus.req_ready_o);
      end
      tick();
      clear = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0100) begin
         miscompares++;
         $display("FAIL clr_regrant: got %b expected 0100", bus.req_ready_o);
      end
      tick();
      idle_reqs();
      tick();
      // In RESP: ready and clear together, clear wins.
      bus.rsp_ready_i = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL clr_resp_pre: valid=%b expected 1", bus.rsp_valid_o);
      end
      tick();
      clear = 1'b0;
      @(negedge clk);
      vectors++;
      if (dbg_state !== IDLE || bus.rsp_valid_o !== 1'b0 || bus.ops_done_o !== 8'(exp_done)) begin
         miscompares++;
         $display("FAIL clr_resp_after: state=%0d valid=%b done=%0d expected IDLE/0/%0d",
                  dbg_state, bus.rsp_valid_o, bus.ops_done_o, exp_done);
      end
      tick();
   endtask

   // Runs right after test_clear: pointer must restart at requester 0.
   task automatic test_round_robin();
      int         exp_k = 0;
      int         grants = 0;
      int         rsps = 0;
      int         last_cyc = 0;
      logic [3:0] oh;
      logic [6:0] exp_e;
      logic [6:0] got_e;
      for (int k = 0; k < N; k++) set_req(k, 5'(k + 1), 5'd10, MODE_ADD);
      bus.rsp_ready_i = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus.req_ready_o !== 4'b0000) begin
            oh = 4'b0001 << exp_k;
            vectors++;
            if (bus.req_ready_o !== oh) begin
               miscompares++;
               $display("FAIL rr_grant%0d: got %b expected %b", grants, bus.req_ready_o, oh);
            end
            if (grants > 0) begin
               vectors++;
               if (cyc - last_cyc != 3) begin
                  miscompares++;
                  $display("FAIL rr_spacing%0d: got %0d cycles expected 3", grants, cyc - last_cyc);
               end
            end
            exp_q.push_back({2'(exp_k), 5'(exp_k + 11)});
            last_cyc = cyc;
            grants++;
            exp_k = (exp_k + 1) % N;
         end
         if (bus.rsp_valid_o === 1'b1) begin
            got_e = {bus.rsp_id_o, bus.rsp_result_o};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rr_unexpected: got id=%0d result=%0d expected no response",
                        bus.rsp_id_o, bus.rsp_result_o);
            end else begin
               exp_e = exp_q.pop_front();
               if (got_e !== exp_e) begin
                  miscompares++;
                  $display("FAIL rr_rsp%0d: got id=%0d result=%0d expected id=%0d result=%0d",
                           rsps, got_e[6:5], got_e[4:0], exp_e[6:5], exp_e[4:0]);
               end
            end
            rsps++;
            exp_done++;
         end
         tick();
         if (grants == 5) idle_reqs();
      end
      vectors++;
      if (grants != 5 || rsps != 5 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rr_totals: grants=%0d rsps=%0d pending=%0d expected 5/5/0",
                  grants, rsps, exp_q.size());
      end
      @(negedge clk);
      vectors++;
      if (bus.ops_done_o !== 8'(exp_done)) begin
         miscompares++;
         $display("FAIL rr_done: got %0d expected %0d", bus.ops_done_o, exp_done);
      end
      tick();
   endtask

   task automatic test_reset_mid_resp();
      set_req(1, 5'd1, 5'd1, MODE_ADD);
      bus.rsp_ready_i = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.req_ready_o !== 4'b0010) begin
         miscompares++;
         $display("FAIL rst_mid_grant: got %b expected 0010", bus.req_ready_o);
      end
      tick();
      idle_reqs();
      tick();
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 5'd2) begin
         miscompares++;
         $display("FAIL rst_mid_pre: valid=%b result=%0d expected 1/2",
                  bus.rsp_valid_o, bus.rsp_result_o);
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.rsp_ready_i = 1'b1;
      exp_done = 0;
      @(negedge clk);
      vectors++;
      if (dbg_state !== IDLE || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0
          || bus.rsp_result_o !== 5'd0 || bus.rsp_id_o !== 2'd0 || bus.ops_done_o !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_mid_after: state=%0d valid=%b busy=%b result=%0d id=%0d done=%0d expected all 0",
                  dbg_state, bus.rsp_valid_o, bus.busy_o, bus.rsp_result_o, bus.rsp_id_o,
                  bus.ops_done_o);
      end
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid_o !== 1'b0 || bus.ops_done_o !== 8'(exp_done)) begin
            miscompares++;
            $display("FAIL rst_mid_lost%0d: valid=%b done=%0d expected 0/0",
                     c, bus.rsp_valid_o, bus.ops_done_o);
         end
         tick();
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      vectors = 0;
      miscompares = 0;
      exp_done = 0;
      test_reset();
      test_single();
      test_wrap_sub();
      test_backpressure();
      test_clear();
      test_round_robin();
      test_reset_mid_resp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
